// File: rtl/instr_loader.sv
// Boot loader: assembles framed big-endian words from a byte stream into
// instruction memory and holds the core in reset until a checksum-clean load.
module instr_loader #(
  parameter int          ADDR_W = 6,
  parameter int unsigned WORDS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic          xfer, load_go, len_bad, last_word;
  logic [CW-1:0] n_words;
  logic [1:0]    byte_cnt;
  logic [7:0]    xor_acc;
  logic [31:0]   word_p0;
  logic [31:0]   word_nx;

  assign xfer      = byte_valid & byte_ready;
  assign load_go   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_bad   = (byte_data == 8'd0) || (32'(byte_data) > WORDS);
  assign last_word = (word_count + CW'(1)) == n_words;
  assign word_nx   = {word_p0[23:0], byte_data};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LEN;
      S_LEN:   if (xfer) state_nx = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (xfer && byte_cnt == 2'd3) state_nx = S_WRITE;
      S_WRITE: state_nx = last_word ? S_CHK : S_DATA;
      S_CHK:   if (xfer) state_nx = (byte_data == xor_acc) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_nx = S_LEN;
      S_ERR:   if (start) state_nx = S_LEN;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      n_words    <= '0;
      byte_cnt   <= '0;
      xor_acc    <= '0;
    end else begin
      byte_ready <= (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CHK);
      im_we      <= (state_nx == S_WRITE);
      cpu_rst    <= (state_nx != S_DONE);
      done       <= (state_nx == S_DONE);
      err        <= (state_nx == S_ERR);
      if (load_go) begin
        word_count <= '0;
        byte_cnt   <= '0;
        xor_acc    <= '0;
      end
      if (state == S_LEN && xfer) n_words <= CW'(byte_data);
      if (state == S_DATA && xfer) begin
        xor_acc  <= xor_acc ^ byte_data;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          im_addr  <= word_count[ADDR_W-1:0];
          im_wdata <= word_nx;
        end
      end
      if (state == S_WRITE) word_count <= word_count + CW'(1);
    end
  end

  // Shift register is pure data; it is fully rewritten before every use.
  always_ff @(posedge clk) begin
    if (state == S_DATA && xfer) word_p0 <= word_nx;
  end

endmodule
